stream_seq_sink: RTL



---
 rtl/stream_seq_sink.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/stream_seq_sink.sv
// stream_seq_sink: receiving end of a valid/ready stream.
// Beats are buffered in a small FIFO, with backpressure when it is full, and
// re-presented on a downstream valid/ready port. A sequence checker watches
// every accepted beat for an incrementing pattern and counts beats and errors.
// Optional build macro STREAM_SINK_STALL_EN adds LFSR-driven pseudo-random
// deassertion of s_rdy for stress testing.
module stream_seq_sink #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_vld,
    output logic              s_rdy,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_vld,
    input  logic              m_rdy,
    output logic [DATA_W-1:0] m_data,
    input  logic              clr_stats,
    output logic              seq_err,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [31:0]       rx_cnt,
    output logic              synced
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]       PTR_ONE  = (AW+1)'(1);
    localparam logic [DATA_W-1:0] DATA_ONE = DATA_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW:0]       wptr_q, wptr_d;
    logic [AW:0]       rptr_q, rptr_d;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              stall;

    logic              synced_q, synced_d;
    logic              seq_err_q, seq_err_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic [31:0]       rx_cnt_q, rx_cnt_d;
    logic [DATA_W-1:0] expected_q, expected_d;

    // Full/empty come from the extra pointer MSB, so all of DEPTH is usable.
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty = (wptr_q == rptr_q);

`ifdef STREAM_SINK_STALL_EN
    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    // Fibonacci LFSR, taps 8,6,5,4; bit 0 requests an upstream stall.
    always_comb begin
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    // LFSR state register, reseeded on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= 8'hA5;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign stall = lfsr_q[0];
`else
    assign stall = 1'b0;
`endif

    // Ready depends only on registered state (and reset), never on m_rdy.
    assign s_rdy  = !full && !stall && !rst;
    assign m_vld  = !empty;
    assign m_data = mem_q[rptr_q[AW-1:0]];

    assign push = s_vld && s_rdy;
    assign pop  = m_vld && m_rdy;

    // Pointer advance on handshakes.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push) begin
            wptr_d = wptr_q + PTR_ONE;
        end
        if (pop) begin
            rptr_d = rptr_q + PTR_ONE;
        end
    end

    // FIFO pointers; reset empties the FIFO and discards stored beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage array; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q[AW-1:0]] <= s_data;
        end
    end

    // Sequence checker next state; clr_stats overrides any same-cycle push.
    always_comb begin
        synced_d   = synced_q;
        expected_d = expected_q;
        err_cnt_d  = err_cnt_q;
        rx_cnt_d   = rx_cnt_q;
        seq_err_d  = 1'b0;
        if (clr_stats) begin
            synced_d  = 1'b0;
            err_cnt_d = '0;
            rx_cnt_d  = '0;
        end else if (push) begin
            rx_cnt_d   = rx_cnt_q + 32'd1;
            expected_d = s_data + DATA_ONE;
            synced_d   = 1'b1;
            if (synced_q && (s_data != expected_q)) begin
                seq_err_d = 1'b1;
                if (err_cnt_q != '1) begin
                    err_cnt_d = err_cnt_q + CNT_ONE;
                end
            end
        end
    end

    // Checker state and statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            synced_q   <= 1'b0;
            expected_q <= '0;
            err_cnt_q  <= '0;
            rx_cnt_q   <= '0;
            seq_err_q  <= 1'b0;
        end else begin
            synced_q   <= synced_d;
            expected_q <= expected_d;
            err_cnt_q  <= err_cnt_d;
            rx_cnt_q   <= rx_cnt_d;
            seq_err_q  <= seq_err_d;
        end
    end

    assign synced  = synced_q;
    assign seq_err = seq_err_q;
    assign err_cnt = err_cnt_q;
    assign rx_cnt  = rx_cnt_q;

endmodule
